fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined Filter-GPU core. It owns PCF, drives a single-outstanding request/ready instruction-memory port, and loads the Fetch/Decode pipeline register (InstrD, PCPlus8D, ValidD). It consumes StallF, StallD and FlushD from the hazard unit plus redirects from Execute and Writeback. It returns MemStallF so the hazard unit can account for memory wait states.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PCF, drives a single-outstanding imem port
// and loads the Fetch/Decode pipeline register.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  BranchTakenE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic                  PCSrcW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCPlus8D,
  output logic                  ValidD,
  output logic                  MemStallF
);

  typedef enum logic [1:0] {S_FETCH, S_KILL, S_HELD} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pcf;
  logic [DATA_WIDTH-1:0] r_redir_pc;
  logic [DATA_WIDTH-1:0] r_skid_instr;
  logic [DATA_WIDTH-1:0] r_skid_pc;
  logic [DATA_WIDTH-1:0] r_instr_d;
  logic [DATA_WIDTH-1:0] r_pcplus8_d;
  logic                  r_valid_d;

  logic                  w_stall;
  logic                  w_redirect;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic                  w_deliver_fetch;
  logic                  w_deliver_held;
  logic                  w_deliver;
  logic [DATA_WIDTH-1:0] w_deliver_instr;
  logic [DATA_WIDTH-1:0] w_deliver_pc;

  assign w_stall    = StallF | StallD;
  assign w_redirect = BranchTakenE | PCSrcW;
  assign w_target   = BranchTakenE ? ALUResultE : ResultW;
  assign w_pc_plus4 = r_pcf + DATA_WIDTH'(4);

  assign w_deliver_fetch = (r_state == S_FETCH) & imem_ready & ~w_redirect & ~w_stall;
  assign w_deliver_held  = (r_state == S_HELD) & ~w_redirect & ~w_stall;
  assign w_deliver       = w_deliver_fetch | w_deliver_held;
  assign w_deliver_instr = w_deliver_held ? r_skid_instr : imem_rdata;
  assign w_deliver_pc    = w_deliver_held ? r_skid_pc    : r_pcf;

  // Gated by rst_n so a request in flight is dropped the moment reset asserts.
  assign imem_req  = rst_n & (r_state != S_HELD);
  assign imem_addr = r_pcf;
  assign MemStallF = rst_n & (((r_state == S_FETCH) & ~imem_ready) | (r_state == S_KILL));

  assign PCF      = r_pcf;
  assign InstrD   = r_instr_d;
  assign PCPlus8D = r_pcplus8_d;
  assign ValidD   = r_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pcf        <= RESET_PC;
      r_redir_pc   <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            if (w_redirect) begin
              r_pcf <= w_target;
            end else if (!w_stall) begin
              r_pcf <= w_pc_plus4;
            end else begin
              r_skid_instr <= imem_rdata;
              r_skid_pc    <= r_pcf;
              r_pcf        <= w_pc_plus4;
              r_state      <= S_HELD;
            end
          end else if (w_redirect) begin
            // Address must stay put until the pending response arrives.
            r_redir_pc <= w_target;
            r_state    <= S_KILL;
          end
        end
        S_KILL: begin
          if (imem_ready) begin
            r_pcf   <= w_redirect ? w_target : r_redir_pc;
            r_state <= S_FETCH;
          end else if (w_redirect) begin
            r_redir_pc <= w_target;
          end
        end
        S_HELD: begin
          if (w_redirect) begin
            r_pcf   <= w_target;
            r_state <= S_FETCH;
          end else if (!w_stall) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d   <= '0;
      r_pcplus8_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (FlushD) begin
      r_instr_d   <= '0;
      r_pcplus8_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (StallD) begin
      r_instr_d   <= r_instr_d;
      r_pcplus8_d <= r_pcplus8_d;
      r_valid_d   <= r_valid_d;
    end else if (w_deliver) begin
      r_instr_d   <= w_deliver_instr;
      r_pcplus8_d <= w_deliver_pc + DATA_WIDTH'(8);
      r_valid_d   <= 1'b1;
    end else begin
      r_instr_d   <= '0;
      r_pcplus8_d <= '0;
      r_valid_d   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr | 0xE0000000.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD;
  logic        BranchTakenE, PCSrcW;
  logic [31:0] ALUResultE, ResultW;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCF, InstrD, PCPlus8D;
  logic        ValidD, MemStallF;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr | 32'hE000_0000;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
    .PCSrcW(PCSrcW), .ResultW(ResultW),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .ValidD(ValidD), .MemStallF(MemStallF)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; StallF = 0; StallD = 0; FlushD = 0;
    BranchTakenE = 0; PCSrcW = 0; ALUResultE = '0; ResultW = '0; imem_ready = 0;
    #2;
    total++; if (PCF !== 32'h0)   begin bad++; $display("FAIL reset_pcf got=%h exp=0", PCF); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus8D !== 32'h0)
      begin bad++; $display("FAIL reset_fd got v=%b i=%h p=%h exp 0", ValidD, InstrD, PCPlus8D); end
    total++; if (MemStallF !== 1'b0) begin bad++; $display("FAIL reset_memstall got=%b exp=0", MemStallF); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin bad++; $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    imem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (InstrD !== (32'hE000_0000 | 32'(i*4)) || PCPlus8D !== 32'(i*4+8) || ValidD !== 1'b1)
        begin bad++; $display("FAIL stream%0d got i=%h p=%h v=%b", i, InstrD, PCPlus8D, ValidD); end
    end
    total++; if (PCF !== 32'h10) begin bad++; $display("FAIL stream_pcf got=%h exp=10", PCF); end
  endtask

  task automatic test_wait();
    imem_ready = 0;
    #1;
    total++; if (MemStallF !== 1'b1) begin bad++; $display("FAIL wait_ms0 got=%b exp=1", MemStallF); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (ValidD !== 1'b0 || PCF !== 32'h10 || MemStallF !== 1'b1)
        begin bad++; $display("FAIL wait_bubble%0d got v=%b pc=%h ms=%b", i, ValidD, PCF, MemStallF); end
    end
    imem_ready = 1;
    #1;
    total++; if (MemStallF !== 1'b0) begin bad++; $display("FAIL wait_ms_end got=%b exp=0", MemStallF); end
    tick();
    total++; if (InstrD !== 32'hE000_0010 || ValidD !== 1'b1 || PCF !== 32'h14)
      begin bad++; $display("FAIL wait_deliver got i=%h v=%b pc=%h", InstrD, ValidD, PCF); end
    tick(); tick(); tick();
  endtask

  task automatic test_load_use();
    StallF = 1; StallD = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (imem_req !== 1'b0 || InstrD !== 32'hE000_001C || PCF !== 32'h24 || MemStallF !== 1'b0)
        begin bad++; $display("FAIL held%0d got req=%b i=%h pc=%h ms=%b", i, imem_req, InstrD, PCF, MemStallF); end
    end
    StallF = 0; StallD = 0;
    tick();
    total++; if (InstrD !== 32'hE000_0020 || PCPlus8D !== 32'h28 || ValidD !== 1'b1)
      begin bad++; $display("FAIL held_release got i=%h p=%h v=%b", InstrD, PCPlus8D, ValidD); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h24)
      begin bad++; $display("FAIL held_nextreq got req=%b addr=%h exp 1/24", imem_req, imem_addr); end
  endtask

  task automatic test_branch_kill();
    for (int i = 0; i < 7; i++) tick();
    total++; if (PCF !== 32'h40) begin bad++; $display("FAIL kill_setup got=%h exp=40", PCF); end
    imem_ready = 0; BranchTakenE = 1; ALUResultE = 32'h100;
    tick();
    BranchTakenE = 0; ALUResultE = 32'h0;
    #1;
    total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || MemStallF !== 1'b1)
      begin bad++; $display("FAIL kill_hold got addr=%h req=%b ms=%b", imem_addr, imem_req, MemStallF); end
    tick();
    total++; if (imem_addr !== 32'h40 || MemStallF !== 1'b1)
      begin bad++; $display("FAIL kill_hold2 got addr=%h ms=%b", imem_addr, MemStallF); end
    imem_ready = 1;
    tick();
    total++; if (PCF !== 32'h100 || ValidD !== 1'b0)
      begin bad++; $display("FAIL kill_discard got pc=%h v=%b exp 100/0", PCF, ValidD); end
    tick();
    total++; if (InstrD !== 32'hE000_0100 || ValidD !== 1'b1)
      begin bad++; $display("FAIL kill_target got i=%h v=%b", InstrD, ValidD); end
  endtask

  task automatic test_dual_redirect();
    BranchTakenE = 1; ALUResultE = 32'h200; PCSrcW = 1; ResultW = 32'h300;
    tick();
    BranchTakenE = 0; PCSrcW = 0;
    total++; if (PCF !== 32'h200 || ValidD !== 1'b0)
      begin bad++; $display("FAIL dual_redirect got pc=%h v=%b exp 200/0", PCF, ValidD); end
    tick();
    total++; if (InstrD !== 32'hE000_0200 || ValidD !== 1'b1 || PCF !== 32'h204)
      begin bad++; $display("FAIL dual_next got i=%h v=%b pc=%h", InstrD, ValidD, PCF); end
    FlushD = 1; StallD = 1;
    tick();
    FlushD = 0; StallD = 0;
    total++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus8D !== 32'h0)
      begin bad++; $display("FAIL flush_stall got v=%b i=%h p=%h exp 0", ValidD, InstrD, PCPlus8D); end
    tick();
    total++; if (InstrD !== 32'hE000_0204 || PCPlus8D !== 32'h20C || ValidD !== 1'b1)
      begin bad++; $display("FAIL flush_skid got i=%h p=%h v=%b", InstrD, PCPlus8D, ValidD); end
  endtask

  task automatic test_held_redirect();
    StallF = 1; StallD = 1;
    tick();
    PCSrcW = 1; ResultW = 32'h300;
    tick();
    PCSrcW = 0; StallF = 0; StallD = 0;
    total++; if (PCF !== 32'h300 || InstrD !== 32'hE000_0204 || imem_req !== 1'b1)
      begin bad++; $display("FAIL held_redir got pc=%h i=%h req=%b", PCF, InstrD, imem_req); end
    tick();
    total++; if (InstrD !== 32'hE000_0300 || ValidD !== 1'b1)
      begin bad++; $display("FAIL held_redir_next got i=%h v=%b", InstrD, ValidD); end
  endtask

  task automatic test_wrap();
    PCSrcW = 1; ResultW = 32'hFFFF_FFFC;
    tick();
    PCSrcW = 0;
    tick();
    total++; if (InstrD !== 32'hFFFF_FFFC || PCPlus8D !== 32'h4 || PCF !== 32'h0)
      begin bad++; $display("FAIL wrap got i=%h p=%h pc=%h exp fffffffc/4/0", InstrD, PCPlus8D, PCF); end
  endtask

  task automatic test_reset_mid();
    PCSrcW = 1; ResultW = 32'h7C;
    tick();
    PCSrcW = 0;
    tick();
    imem_ready = 0;
    #1;
    total++; if (PCF !== 32'h80 || ValidD !== 1'b1 || MemStallF !== 1'b1)
      begin bad++; $display("FAIL rstmid_setup got pc=%h v=%b ms=%b", PCF, ValidD, MemStallF); end
    rst_n = 0;
    #1;
    total++; if (PCF !== 32'h0 || ValidD !== 1'b0 || imem_req !== 1'b0 || MemStallF !== 1'b0)
      begin bad++; $display("FAIL rstmid got pc=%h v=%b req=%b ms=%b", PCF, ValidD, imem_req, MemStallF); end
    imem_ready = 1;
    tick();
    total++; if (PCF !== 32'h0 || InstrD !== 32'h0 || ValidD !== 1'b0)
      begin bad++; $display("FAIL rstmid_ignore got pc=%h i=%h v=%b", PCF, InstrD, ValidD); end
    rst_n = 1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin bad++; $display("FAIL rstmid_req got req=%b addr=%h", imem_req, imem_addr); end
    tick();
    total++; if (InstrD !== 32'hE000_0000 || ValidD !== 1'b1)
      begin bad++; $display("FAIL rstmid_first got i=%h v=%b", InstrD, ValidD); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_load_use();
    test_branch_kill();
    test_dual_redirect();
    test_held_redirect();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
